axi_stream_frame_unpacker: RTL

//  AXI-stream slave that receives one 64-word frame of sign-extended 32-bit coefficients
//  and stores it in an 8x8 buffer. It then replays the frame as eight rows of eight 12-bit

---
 rtl/axi_stream_frame_unpacker_if.sv | 32 +++
 rtl/axi_stream_frame_unpacker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_frame_unpacker_if.sv
// rtl/axi_stream_frame_unpacker_if.sv - coefficient input stream bundle for the frame unpacker
//
// Purpose: carries one 32-bit signed coefficient per beat with a valid/ready
//          handshake and an end-of-frame marker.
// Signals:
//   s_axis_valid  source -> sink   word valid
//   s_axis_ready  sink   -> source sink can accept a word
//   s_axis_data   source -> sink   32-bit signed word
//   s_axis_last   source -> sink   last word of the frame
// Modports:
//   master  the producer of the stream
//   slave   the consumer of the stream (the frame unpacker)
interface axi_stream_frame_unpacker_if;
   logic        s_axis_valid;
   logic        s_axis_ready;
   logic [31:0] s_axis_data;
   logic        s_axis_last;

   modport master (
      output s_axis_valid,
      output s_axis_data,
      output s_axis_last,
      input  s_axis_ready
   );

   modport slave (
      input  s_axis_valid,
      input  s_axis_data,
      input  s_axis_last,
      output s_axis_ready
   );
endinterface

// File: rtl/axi_stream_frame_unpacker.sv
// rtl/axi_stream_frame_unpacker.sv - 64-word coefficient frame to 8x8 row unpacker
//
// Purpose: accepts one 64-word frame of signed 32-bit coefficients, narrows each
//          word to OUT_W bits (saturating or truncating), stores it in an 8x8
//          buffer and replays the buffer as eight rows of eight lanes.
//          Short frames are zero-padded; long/unterminated frames are cut at 64.
// Parameters:
//   OUT_W   lane width in bits
//   SAT_EN  1: clamp out-of-range words to the OUT_W signed range; 0: keep low bits
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous reset, active-low
//   s_axis       input coefficient stream (slave modport)
//   o_row_data   lanes 0..7, lane k at [k*OUT_W +: OUT_W], signed
//   o_row_idx    row number of o_row_data
//   o_row_valid  row presented
//   i_row_ready  downstream accepts the row
//   o_len_err    one-cycle pulse: frame ended early or had no last marker
//   o_sat        one-cycle pulse: the previously accepted word was clamped
module axi_stream_frame_unpacker #(
   parameter int OUT_W  = 12,
   parameter bit SAT_EN = 1'b1
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   axi_stream_frame_unpacker_if.slave  s_axis,
   output logic [8*OUT_W-1:0]          o_row_data,
   output logic [2:0]                  o_row_idx,
   output logic                        o_row_valid,
   input  logic                        i_row_ready,
   output logic                        o_len_err,
   output logic                        o_sat
);

   typedef enum logic [1:0] {
      ST_RECV = 2'd0,
      ST_PAD  = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
   localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (OUT_W - 1));

   state_t               state_q, state_d;
   logic [5:0]           wr_pt_q, wr_pt_d;
   logic [2:0]           rd_row_q, rd_row_d;
   logic                 ready_q, ready_d;
   logic                 row_valid_d;
   logic [2:0]           row_idx_d;
   logic [8*OUT_W-1:0]   row_data_d;
   logic                 len_err_d;
   logic                 sat_d;

   logic                 mem_we;
   logic [OUT_W-1:0]     mem_wdata;
   logic [OUT_W-1:0]     mem_q [64];

   logic                 beat;
   logic                 row_take;
   logic [OUT_W-1:0]     conv_word;
   logic                 conv_sat;
   logic [2:0]           rd_sel;
   logic [8*OUT_W-1:0]   rd_row_word;

   // Ready is registered, so it cannot depend on valid in the same cycle and
   // rises one clock after reset release or after the last row is taken.
   assign s_axis.s_axis_ready = ready_q;
   assign beat                = ready_q & s_axis.s_axis_valid;
   assign row_take            = o_row_valid & i_row_ready;

   // Narrow the incoming word to the lane width.
   always_comb begin
      conv_word = s_axis.s_axis_data[OUT_W-1:0];
      conv_sat  = 1'b0;
      if (SAT_EN) begin
         if ($signed(s_axis.s_axis_data) > SAT_MAX) begin
            conv_word = SAT_MAX[OUT_W-1:0];
            conv_sat  = 1'b1;
         end else if ($signed(s_axis.s_axis_data) < SAT_MIN) begin
            conv_word = SAT_MIN[OUT_W-1:0];
            conv_sat  = 1'b1;
         end
      end
   end

   // Row to load into the output register: the next row when the current one
   // is being taken (no bubble between rows), otherwise the current row.
   assign rd_sel = (row_take && (rd_row_q != 3'd7)) ? (rd_row_q + 3'd1) : rd_row_q;

   always_comb begin
      rd_row_word = '0;
      for (int k = 0; k < 8; k++) begin
         rd_row_word[k*OUT_W +: OUT_W] = mem_q[{rd_sel, 3'(k)}];
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      wr_pt_d     = wr_pt_q;
      rd_row_d    = rd_row_q;
      ready_d     = ready_q;
      row_valid_d = o_row_valid;
      row_idx_d   = o_row_idx;
      row_data_d  = o_row_data;
      len_err_d   = 1'b0;
      sat_d       = 1'b0;
      mem_we      = 1'b0;
      mem_wdata   = conv_word;

      case (state_q)
         ST_RECV: begin
            ready_d = 1'b1;
            if (beat) begin
               mem_we  = 1'b1;
               wr_pt_d = wr_pt_q + 6'd1;
               sat_d   = conv_sat;
               if (wr_pt_q == 6'd63) begin
                  // Buffer full: emit regardless; a missing last is reported.
                  state_d   = ST_EMIT;
                  ready_d   = 1'b0;
                  len_err_d = ~s_axis.s_axis_last;
               end else if (s_axis.s_axis_last) begin
                  state_d   = ST_PAD;
                  ready_d   = 1'b0;
                  len_err_d = 1'b1;
               end
            end
         end

         ST_PAD: begin
            ready_d   = 1'b0;
            mem_we    = 1'b1;
            mem_wdata = '0;
            wr_pt_d   = wr_pt_q + 6'd1;
            if (wr_pt_q == 6'd63) begin
               state_d = ST_EMIT;
            end
         end

         ST_EMIT: begin
            ready_d = 1'b0;
            if (!o_row_valid) begin
               // First cycle in EMIT: register row rd_row.
               row_valid_d = 1'b1;
               row_idx_d   = rd_sel;
               row_data_d  = rd_row_word;
            end else if (row_take) begin
               if (rd_row_q == 3'd7) begin
                  row_valid_d = 1'b0;
                  rd_row_d    = 3'd0;
                  wr_pt_d     = 6'd0;
                  state_d     = ST_RECV;
                  ready_d     = 1'b1;
               end else begin
                  rd_row_d   = rd_sel;
                  row_idx_d  = rd_sel;
                  row_data_d = rd_row_word;
               end
            end
         end

         default: begin
            state_d = ST_RECV;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= ST_RECV;
         wr_pt_q     <= 6'd0;
         rd_row_q    <= 3'd0;
         ready_q     <= 1'b0;
         o_row_valid <= 1'b0;
         o_row_idx   <= 3'd0;
         o_row_data  <= '0;
         o_len_err   <= 1'b0;
         o_sat       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_pt_q     <= wr_pt_d;
         rd_row_q    <= rd_row_d;
         ready_q     <= ready_d;
         o_row_valid <= row_valid_d;
         o_row_idx   <= row_idx_d;
         o_row_data  <= row_data_d;
         o_len_err   <= len_err_d;
         o_sat       <= sat_d;
      end
   end

   // Frame buffer: contents are meaningless after reset, so it is not reset.
   always_ff @(posedge i_clk) begin
      if (mem_we) begin
         mem_q[wr_pt_q] <= mem_wdata;
      end
   end

endmodule
